// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: bundles the requester-side and next-level-side signals of
// the cache arbiter.
//   master modport : arbiter view (drives grant, req_valid/req_rdata, next_*)
//   slave modport  : environment view (drives req_* requests, next_valid/rdata)
interface cache_arbiter_if #(
    parameter int unsigned REQUESTERS = 2,
    parameter int unsigned ADDRBITS   = 32,
    parameter int unsigned DATABITS   = 32
);
    // Requester side
    logic [REQUESTERS-1:0]          req_request;
    logic [REQUESTERS-1:0]          req_write;
    logic [REQUESTERS*ADDRBITS-1:0] req_addr;
    logic [REQUESTERS*DATABITS-1:0] req_wdata;
    logic [REQUESTERS-1:0]          req_valid;
    logic [DATABITS-1:0]            req_rdata;
    logic [REQUESTERS-1:0]          grant;

    // Next-level side
    logic                           next_request;
    logic                           next_write;
    logic [ADDRBITS-1:0]            next_addr;
    logic [DATABITS-1:0]            next_wdata;
    logic                           next_valid;
    logic [DATABITS-1:0]            next_rdata;

    modport master (
        input  req_request, req_write, req_addr, req_wdata,
        input  next_valid, next_rdata,
        output req_valid, req_rdata, grant,
        output next_request, next_write, next_addr, next_wdata
    );

    modport slave (
        output req_request, req_write, req_addr, req_wdata,
        output next_valid, next_rdata,
        input  req_valid, req_rdata, grant,
        input  next_request, next_write, next_addr, next_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one next-level cache port between REQUESTERS
// lower-level caches. Round-robin selection, one outstanding transaction.
// The winner's write/addr/wdata are latched, forwarded as next_*, and the
// next-level response is returned to the winner only as a one-cycle req_valid.
//
// Ports:
//   clock : system clock, all state on posedge
//   reset : asynchronous active-low reset
//   bus   : cache_arbiter_if.master (req_* requester side, next_* next level,
//           grant = one-hot current owner, zero when idle)
//
// Optional feature macro: WRITEBACK_PRIORITY_EN
//   defined   : pending writes (writebacks) arbitrate ahead of reads; the
//               round-robin pointer is shared by both classes, so continuous
//               writes can starve reads.
//   undefined : pure round-robin, req_write does not affect selection.
module cache_arbiter #(
    parameter int unsigned REQUESTERS = 2,
    parameter int unsigned ADDRBITS   = 32,
    parameter int unsigned DATABITS   = 32
) (
    input  logic            clock,
    input  logic            reset,
    cache_arbiter_if.master bus
);
    localparam int unsigned IDXBITS = $clog2(REQUESTERS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDXBITS-1:0]     last_grant_q, last_grant_d;
    logic [IDXBITS-1:0]     winner_q, winner_d;
    logic [REQUESTERS-1:0]  grant_q, grant_d;
    logic [REQUESTERS-1:0]  req_valid_q, req_valid_d;
    logic [DATABITS-1:0]    req_rdata_q, req_rdata_d;
    logic                   next_request_q, next_request_d;
    logic                   next_write_q, next_write_d;
    logic [ADDRBITS-1:0]    next_addr_q, next_addr_d;
    logic [DATABITS-1:0]    next_wdata_q, next_wdata_d;

    logic [REQUESTERS-1:0]  cand_c;
    logic [IDXBITS-1:0]     pick_c;
    logic                   pick_valid_c;
    logic                   sel_write_c;
    logic [ADDRBITS-1:0]    sel_addr_c;
    logic [DATABITS-1:0]    sel_wdata_c;

    // Candidate set for this arbitration round
`ifdef WRITEBACK_PRIORITY_EN
    always_comb begin
        cand_c = bus.req_request & bus.req_write;
        if (cand_c == '0) begin
            cand_c = bus.req_request;
        end
    end
`else
    logic unused_write_c;
    assign cand_c         = bus.req_request;
    assign unused_write_c = ^bus.req_write;
`endif

    // Round-robin scan: first candidate above last_grant, wrapping
    always_comb begin
        logic [IDXBITS-1:0] idx;
        idx          = '0;
        pick_c       = last_grant_q;
        pick_valid_c = 1'b0;
        for (int unsigned k = 1; k <= REQUESTERS; k++) begin
            idx = IDXBITS'((32'(last_grant_q) + k) % REQUESTERS);
            if (!pick_valid_c && cand_c[idx]) begin
                pick_c       = idx;
                pick_valid_c = 1'b1;
            end
        end
    end

    // Payload mux for the selected requester
    always_comb begin
        sel_write_c = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (32'(pick_c) == i) begin
                sel_write_c = bus.req_write[i];
                sel_addr_c  = bus.req_addr[i*ADDRBITS +: ADDRBITS];
                sel_wdata_c = bus.req_wdata[i*DATABITS +: DATABITS];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        winner_d       = winner_q;
        grant_d        = grant_q;
        req_valid_d    = '0;
        req_rdata_d    = req_rdata_q;
        next_request_d = next_request_q;
        next_write_d   = next_write_q;
        next_addr_d    = next_addr_q;
        next_wdata_d   = next_wdata_q;

        unique case (state_q)
            IDLE: begin
                grant_d        = '0;
                next_request_d = 1'b0;
                if (pick_valid_c) begin
                    winner_d       = pick_c;
                    grant_d        = REQUESTERS'(1) << pick_c;
                    next_write_d   = sel_write_c;
                    next_addr_d    = sel_addr_c;
                    next_wdata_d   = sel_wdata_c;
                    next_request_d = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.next_valid) begin
                    req_rdata_d    = bus.next_rdata;
                    req_valid_d    = grant_q;
                    next_request_d = 1'b0;
                    state_d        = RESPOND;
                end
            end
            RESPOND: begin
                last_grant_d = winner_q;
                grant_d      = '0;
                state_d      = IDLE;
            end
            default: begin
                grant_d        = '0;
                next_request_d = 1'b0;
                state_d        = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            last_grant_q   <= IDXBITS'(REQUESTERS - 1);
            winner_q       <= '0;
            grant_q        <= '0;
            req_valid_q    <= '0;
            req_rdata_q    <= '0;
            next_request_q <= 1'b0;
            next_write_q   <= 1'b0;
            next_addr_q    <= '0;
            next_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            winner_q       <= winner_d;
            grant_q        <= grant_d;
            req_valid_q    <= req_valid_d;
            req_rdata_q    <= req_rdata_d;
            next_request_q <= next_request_d;
            next_write_q   <= next_write_d;
            next_addr_q    <= next_addr_d;
            next_wdata_q   <= next_wdata_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.req_valid    = req_valid_q;
    assign bus.req_rdata    = req_rdata_q;
    assign bus.next_request = next_request_q;
    assign bus.next_write   = next_write_q;
    assign bus.next_addr    = next_addr_q;
    assign bus.next_wdata   = next_wdata_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter: table of directed transactions, hand-written
// corner sequences, then random transactions against a round-robin model.
module tb_cache_arbiter;
    localparam int unsigned R = 2;
    localparam int unsigned A = 32;
    localparam int unsigned D = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   model_lg;

    cache_arbiter_if #(.REQUESTERS(R), .ADDRBITS(A), .DATABITS(D)) bus ();

    cache_arbiter #(.REQUESTERS(R), .ADDRBITS(A), .DATABITS(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  mask;
        logic [1:0]  wmask;
        logic [31:0] a0, a1, wd0, wd1;
        int          lat;
        logic [31:0] rdata;
        logic [1:0]  exp_grant;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_write;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic [1:0] mask, input logic [1:0] wmask,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] wd0, input logic [31:0] wd1,
                                input int lat, input logic [31:0] rdata,
                                input logic [1:0] eg, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic ew);
        vec_t v;
        v.mask = mask; v.wmask = wmask; v.a0 = a0; v.a1 = a1;
        v.wd0 = wd0; v.wd1 = wd1; v.lat = lat; v.rdata = rdata;
        v.exp_grant = eg; v.exp_addr = ea; v.exp_wdata = ewd; v.exp_write = ew;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction, entered and left in IDLE (just after an edge)
    task automatic run_txn(input vec_t v, input string tag);
        bus.req_request = v.mask;
        bus.req_write   = v.wmask;
        bus.req_addr    = {v.a1, v.a0};
        bus.req_wdata   = {v.wd1, v.wd0};
        bus.next_valid  = 1'b0;
        tick();
        chk($sformatf("%s grant", tag), 64'(bus.grant), 64'(v.exp_grant));
        chk($sformatf("%s next_request", tag), 64'(bus.next_request), 64'd1);
        chk($sformatf("%s next_addr", tag), 64'(bus.next_addr), 64'(v.exp_addr));
        chk($sformatf("%s next_wdata", tag), 64'(bus.next_wdata), 64'(v.exp_wdata));
        chk($sformatf("%s next_write", tag), 64'(bus.next_write), 64'(v.exp_write));
        chk($sformatf("%s req_valid early", tag), 64'(bus.req_valid), 64'd0);
        for (int c = 0; c < v.lat; c++) begin
            bus.req_addr  = {$urandom, $urandom};
            bus.req_wdata = {$urandom, $urandom};
            bus.req_write = 2'($urandom);
            tick();
            chk($sformatf("%s hold next_addr", tag), 64'(bus.next_addr), 64'(v.exp_addr));
            chk($sformatf("%s hold next_request", tag), 64'(bus.next_request), 64'd1);
            chk($sformatf("%s hold req_valid", tag), 64'(bus.req_valid), 64'd0);
        end
        bus.next_valid = 1'b1;
        bus.next_rdata = v.rdata;
        tick();
        bus.next_valid = 1'b0;
        bus.next_rdata = $urandom;
        chk($sformatf("%s req_valid", tag), 64'(bus.req_valid), 64'(v.exp_grant));
        chk($sformatf("%s req_rdata", tag), 64'(bus.req_rdata), 64'(v.rdata));
        chk($sformatf("%s next_request drop", tag), 64'(bus.next_request), 64'd0);
        chk($sformatf("%s respond next_addr", tag), 64'(bus.next_addr), 64'(v.exp_addr));
        tick();
        bus.req_request = '0;
        chk($sformatf("%s req_valid pulse end", tag), 64'(bus.req_valid), 64'd0);
        chk($sformatf("%s grant cleared", tag), 64'(bus.grant), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk($sformatf("%s grant", tag), 64'(bus.grant), 64'd0);
        chk($sformatf("%s req_valid", tag), 64'(bus.req_valid), 64'd0);
        chk($sformatf("%s req_rdata", tag), 64'(bus.req_rdata), 64'd0);
        chk($sformatf("%s next_request", tag), 64'(bus.next_request), 64'd0);
        chk($sformatf("%s next_write", tag), 64'(bus.next_write), 64'd0);
        chk($sformatf("%s next_addr", tag), 64'(bus.next_addr), 64'd0);
        chk($sformatf("%s next_wdata", tag), 64'(bus.next_wdata), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [1:0] mask, wm, cand;
        int win, idx;

        bus.req_request = '0;
        bus.req_write   = '0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.next_valid  = 1'b0;
        bus.next_rdata  = '0;

        //                mask   wmask a0            a1            wd0           wd1           lat rdata         grant addr          wdata         write
        vecs[0] = mk(2'b01, 2'b00, 32'h0000_1000, 32'h0000_2000, 32'h11, 32'h22, 3, 32'hDEAD_BEEF, 2'b01, 32'h0000_1000, 32'h11, 1'b0);
        vecs[1] = mk(2'b11, 2'b00, 32'h0000_1100, 32'h0000_2100, 32'h33, 32'h44, 0, 32'h0123_4567, 2'b10, 32'h0000_2100, 32'h44, 1'b0);
        vecs[2] = mk(2'b11, 2'b00, 32'h0000_1200, 32'h0000_2200, 32'h55, 32'h66, 1, 32'h89AB_CDEF, 2'b01, 32'h0000_1200, 32'h55, 1'b0);
        vecs[3] = mk(2'b11, 2'b00, 32'h0000_1300, 32'h0000_2300, 32'h77, 32'h88, 2, 32'hCAFE_F00D, 2'b10, 32'h0000_2300, 32'h88, 1'b0);
        vecs[4] = mk(2'b11, 2'b00, 32'h0000_1400, 32'h0000_2400, 32'h99, 32'hAA, 0, 32'h0000_0000, 2'b01, 32'h0000_1400, 32'h99, 1'b0);
        vecs[5] = mk(2'b10, 2'b00, 32'h0000_1500, 32'h0000_2500, 32'hBB, 32'hCC, 1, 32'hFFFF_FFFF, 2'b10, 32'h0000_2500, 32'hCC, 1'b0);
`ifdef WRITEBACK_PRIORITY_EN
        vecs[6] = mk(2'b11, 2'b10, 32'h0000_1600, 32'h0000_2600, 32'hDD, 32'hEE, 0, 32'h1234_5678, 2'b10, 32'h0000_2600, 32'hEE, 1'b1);
        vecs[7] = mk(2'b11, 2'b01, 32'h0000_1700, 32'h0000_2700, 32'hF0, 32'hF1, 2, 32'h8765_4321, 2'b01, 32'h0000_1700, 32'hF0, 1'b1);
`else
        vecs[6] = mk(2'b11, 2'b10, 32'h0000_1600, 32'h0000_2600, 32'hDD, 32'hEE, 0, 32'h1234_5678, 2'b01, 32'h0000_1600, 32'hDD, 1'b0);
        vecs[7] = mk(2'b11, 2'b01, 32'h0000_1700, 32'h0000_2700, 32'hF0, 32'hF1, 2, 32'h8765_4321, 2'b10, 32'h0000_2700, 32'hF1, 1'b0);
`endif
        vecs[8] = mk(2'b01, 2'b00, 32'h0000_1800, 32'h0000_2800, 32'hF2, 32'hF3, 0, 32'hA5A5_A5A5, 2'b01, 32'h0000_1800, 32'hF2, 1'b0);

        do_reset();

        // Directed table, starting from the reset pointer (requester 0 first)
        for (int n = 0; n < 9; n++) begin
            run_txn(vecs[n], $sformatf("vec%0d", n));
        end

        // Address change after grant is ignored
        bus.req_request = 2'b01;
        bus.req_write   = 2'b00;
        bus.req_addr    = {32'h0, 32'h10};
        tick();
        chk("addrchg grant", 64'(bus.grant), 64'd1);
        chk("addrchg next_addr", 64'(bus.next_addr), 64'h10);
        bus.req_addr = {32'h0, 32'h20};
        tick();
        chk("addrchg hold", 64'(bus.next_addr), 64'h10);
        bus.next_valid = 1'b1;
        bus.next_rdata = 32'h5555_AAAA;
        tick();
        bus.next_valid = 1'b0;
        chk("addrchg respond addr", 64'(bus.next_addr), 64'h10);
        chk("addrchg req_valid", 64'(bus.req_valid), 64'd1);
        tick();
        bus.req_request = '0;

        // Stray next_valid in IDLE with no requests
        bus.next_valid = 1'b1;
        tick();
        bus.next_valid = 1'b0;
        chk("stray grant", 64'(bus.grant), 64'd0);
        chk("stray req_valid", 64'(bus.req_valid), 64'd0);
        chk("stray next_request", 64'(bus.next_request), 64'd0);
        tick();
        chk("stray req_valid later", 64'(bus.req_valid), 64'd0);
        chk("stray grant later", 64'(bus.grant), 64'd0);

        // Reset during ISSUE: immediate abort, pointer back to requester 0
        bus.req_request = 2'b10;
        bus.req_addr    = {32'h0000_ABCD, 32'h0};
        tick();
        chk("midreset issuing", 64'(bus.next_request), 64'd1);
        chk("midreset grant", 64'(bus.grant), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("midreset async");
        bus.req_request = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();
        run_txn(mk(2'b11, 2'b00, 32'h0000_3000, 32'h0000_4000, 32'h1, 32'h2, 1, 32'h0F0F_0F0F,
                   2'b01, 32'h0000_3000, 32'h1, 1'b0), "postreset");

        // Random transactions against the round-robin model
        do_reset();
        model_lg = R - 1;
        for (int n = 0; n < 60; n++) begin
            mask = 2'($urandom_range(0, 3));
            wm   = 2'($urandom);
            if (mask == 2'b00) begin
                bus.req_request = '0;
                bus.next_valid  = 1'($urandom);
                tick();
                bus.next_valid = 1'b0;
                chk("rand idle grant", 64'(bus.grant), 64'd0);
                chk("rand idle next_request", 64'(bus.next_request), 64'd0);
                chk("rand idle req_valid", 64'(bus.req_valid), 64'd0);
            end else begin
                cand = mask;
`ifdef WRITEBACK_PRIORITY_EN
                if ((mask & wm) != 2'b00) cand = mask & wm;
`endif
                win = -1;
                for (int k = 1; k <= int'(R); k++) begin
                    idx = (model_lg + k) % int'(R);
                    if (win < 0 && cand[idx]) win = idx;
                end
                v.mask  = mask;
                v.wmask = wm;
                v.a0    = $urandom;
                v.a1    = $urandom;
                v.wd0   = $urandom;
                v.wd1   = $urandom;
                v.lat   = int'($urandom_range(0, 3));
                v.rdata = $urandom;
                v.exp_grant = (win == 0) ? 2'b01 : 2'b10;
                v.exp_addr  = (win == 0) ? v.a0 : v.a1;
                v.exp_wdata = (win == 0) ? v.wd0 : v.wd1;
                v.exp_write = wm[win];
                run_txn(v, $sformatf("rand%0d", n));
                model_lg = win;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares one next-level cache interface between REQUESTERS lower-level caches, e.g. the L1 instruction and L1 data caches in front of a unified L2.
- Uses round-robin fairness and allows exactly one outstanding transaction at a time.
- Sits between the requesters' miss/writeback ports and the next level's slave port.
- Latches the winning request, forwards it, waits for completion, then returns the response to the winner only.

Parameters:
REQUESTERS, 2, number of requesting caches (>=2)
ADDRBITS, 32, address width
DATABITS, 32, data word width
IDXBITS, $clog2(REQUESTERS), width of grant index (localparam)

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-low reset
req_request  input  REQUESTERS  per-requester request, held high until its req_valid
req_write  input  REQUESTERS  1 = write (writeback), 0 = read (line fill)
req_addr  input  REQUESTERS*ADDRBITS  packed per-requester address
req_wdata  input  REQUESTERS*DATABITS  packed per-requester write data
req_valid  output  REQUESTERS  one-cycle completion pulse to the winner
req_rdata  output  DATABITS  read data, meaningful only while req_valid is high
grant  output  REQUESTERS  one-hot current owner, zero when idle
next_request  output  1  request to next level, held until next_valid
next_write  output  1  latched write flag
next_addr  output  ADDRBITS  latched address
next_wdata  output  DATABITS  latched write data
next_valid  input  1  next-level completion, sampled only in ISSUE
next_rdata  input  DATABITS  next-level read data, sampled with next_valid

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, all outputs 0, last_grant=REQUESTERS-1, so requester 0 wins first.
- All outputs are registered or decoded from state. There is no combinational path from any req_* input to any next_* output.
- States: IDLE, ISSUE, RESPOND.
- IDLE:
  - If any req_request bit is set, select the winner: the first set bit scanning upward from last_grant+1, wrapping modulo REQUESTERS.
  - Latch the winner's write, addr and wdata into next_*; set grant one-hot; go to ISSUE.
  - With no request, stay in IDLE with grant=0.
- ISSUE:
  - next_request=1; latched next_* fields stay stable.
  - On next_valid=1: capture next_rdata into req_rdata, go to RESPOND.
  - Otherwise stay in ISSUE. There is no timeout.
- RESPOND:
  - req_valid[winner]=1 for exactly one cycle; next_request=0.
  - last_grant<=winner; grant cleared on the exit edge; go to IDLE.
- Requester rule: drop req_request on the edge where req_valid is sampled high. A request still high in IDLE is treated as a new request.
- Latency: request sampled at edge N, next_request high in cycle N+1. If next_valid arrives the same cycle, req_valid is high in cycle N+2. Minimum 2 cycles per transaction; back-to-back grants need one IDLE cycle between transactions (3-cycle cadence).
- Input changes:
  - Changes to a requester's req_* fields after its grant are ignored.
  - A non-winning requester deasserting in IDLE is legal.
- Wrap-around: when last_grant=REQUESTERS-1, the scan starts at index 0.
- Simultaneous events: all requesters high with rotating ownership yields a strict rotation 0,1,...,REQUESTERS-1,0.
- Reset mid-transaction: abort immediately to the reset values. The transaction is not replayed. The next level must tolerate a dropped next_request.
- next_valid in IDLE or RESPOND is ignored.

Optional Feature:
- Macro: WRITEBACK_PRIORITY_EN.
- Defined: in IDLE, if any requesting bit has req_write=1, arbitrate round-robin among write requests only; reads arbitrate only when no write is pending. last_grant is shared between both classes.
- Not defined: pure round-robin, req_write is irrelevant to selection.
- Reads can starve while writes are continuous. This is accepted and documented.

Test Plan:
- Reset then single request: req_request=01, req_write=0, addr0=0x0000_1000, next_valid asserted 3 cycles after next_request -> next_addr=0x1000, next_write=0, grant=01; req_valid=01 one cycle with req_rdata equal to next_rdata (0xDEADBEEF); then grant=00.
- Both requesting continuously for 4 transactions -> grant order 01,10,01,10; each req_valid is a single pulse on the correct bit only.
- Requester 0 changes addr from 0x10 to 0x20 while in ISSUE -> next_addr stays 0x10 until RESPOND.
- Assert reset while in ISSUE with next_request=1 -> all outputs 0 asynchronously. After release, requester 0 wins first.
- Stray next_valid=1 pulse in IDLE with no requests -> no state change, req_valid stays 00.
- With WRITEBACK_PRIORITY_EN: req0 read and req1 write simultaneous, last_grant=1 -> req1 granted first. Without the macro -> req0 granted first.
